sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
- Downstream stage of the 8-bit ripple-carry adder: consumes each {c_out, sum} result and accumulates it into a wider running total.
- Takes a fixed number of samples per run, selected at start, then reports the total, the carry-event count and a sticky saturation flag.
- Gives the adder datapath a multi-operand summing capability with a simple valid/ready input handshake.

Parameters:
- DATA_W, 8, width of adder sum input.
- ACC_W, 16, width of accumulator; must be greater than DATA_W+1.
- CNT_W, 8, width of sample-count and carry-count registers.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- num_samples  input  CNT_W  samples per run; latched on accepted start.
- in_valid  input  1  in_sum/in_c_out carry a valid adder result.
- in_ready  output  1  block accepts a result this cycle.
- in_sum  input  DATA_W  adder sum.
- in_c_out  input  1  adder carry-out.
- acc_out  output  ACC_W  running/final total.
- carry_cnt  output  CNT_W  number of accepted samples with in_c_out=1.
- sample_cnt  output  CNT_W  number of accepted samples this run.
- busy  output  1  high in ACCUM.
- done  output  1  one-cycle pulse at end of run.
- ovf  output  1  sticky; accumulator saturated this run.

Behaviour:
- Reset value of all outputs is 0, and the state is IDLE.
- rst has priority over start and in_valid; asserting it mid-run abandons the run at the next edge.
- States are IDLE, ACCUM and DONE. in_ready = (state==ACCUM), decoded from the state register with no input dependence; busy is the same signal.
- IDLE:
  - start=1 clears acc_out, carry_cnt, sample_cnt and ovf, and latches num_samples.
  - If num_samples != 0, go to ACCUM; if num_samples == 0, go to DONE.
  - All other inputs are ignored.
- ACCUM:
  - A transfer occurs when in_valid && in_ready at the edge.
  - The addend is the 9-bit value {in_c_out, in_sum}, zero-extended to ACC_W+1.
  - If acc_out + addend exceeds 2^ACC_W-1, acc_out becomes all-ones and ovf becomes 1. Otherwise acc_out = acc_out + addend.
  - sample_cnt increments on every transfer. carry_cnt increments when in_c_out=1 and saturates at all-ones.
  - If the transfer makes sample_cnt equal the latched count, go to DONE.
  - start is ignored. in_valid=0 holds all state.
- DONE: lasts one cycle with done=1 and in_ready=0, then returns to IDLE. start is ignored in this state.
- Latency: a transfer at edge k is visible on acc_out, sample_cnt and carry_cnt after edge k. done is high during the cycle after the final transfer.
- acc_out, carry_cnt, sample_cnt and ovf hold their final values in IDLE until the next accepted start or reset.
- num_samples changing mid-run has no effect.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> every output 0, in_ready=0.
- Basic run: start with num_samples=7, then feed the adder results for (2,3), (2,8), (12,14), (27,13), (18,32), (112,20), (200,100).
  - The last pair arrives as sum=44, c_out=1.
  - Required: acc_out=563, carry_cnt=1, sample_cnt=7, ovf=0.
  - done high exactly one cycle after the 7th transfer, then IDLE.
- Handshake gaps: same run with in_valid low for 3 cycles between samples -> identical final values. No accumulation while in_valid=0 or in_ready=0, including in IDLE/DONE.
- Saturation: num_samples=200, every sample {c_out=1, sum=255} -> acc_out=65535, ovf=1 sticky to run end, carry_cnt=200, done after the 200th transfer.
- Zero count: start with num_samples=0 -> done pulses on the cycle after start, acc_out=0, no sample accepted.
- Reset mid-run: num_samples=5, reset after 3 transfers -> next cycle is IDLE with all outputs 0. A start pulse during ACCUM (without reset) does not clear or restart the run.

Source files
------------

// File: rtl/sum_accumulator.sv
// ============================================================================
// Module   : sum_accumulator
// Brief    : Accumulates a fixed-length run of {c_out, sum} adder results into
//            a saturating running total, counting samples and carry events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_c_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  carry_cnt,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_accum = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] c_acc_max = {ACC_W{1'b1}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_carry_cnt;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_target;
  logic             r_ovf;

  logic             w_accepting;
  logic             w_transfer;
  logic             w_start_ok;
  logic [ACC_W:0]   w_addend;
  logic [ACC_W:0]   w_sum;
  logic [CNT_W-1:0] w_sample_nxt;
  logic             w_last;

  // One spare bit above the accumulator exposes overflow of the addition.
  assign w_addend     = {{(ACC_W-DATA_W){1'b0}}, in_c_out, in_sum};
  assign w_sum        = {1'b0, r_acc} + w_addend;
  assign w_accepting  = (r_state == c_accum);
  assign w_transfer   = in_valid && w_accepting;
  assign w_start_ok   = start && (r_state == c_idle);
  assign w_sample_nxt = r_sample_cnt + c_cnt_one;
  assign w_last       = (w_sample_nxt == r_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (start) begin
          w_state_nxt = (num_samples == '0) ? c_done : c_accum;
        end
      end
      c_accum: begin
        if (w_transfer && w_last) begin
          w_state_nxt = c_done;
        end
      end
      c_done:  w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    in_ready = w_accepting;
    busy     = w_accepting;
    done     = (r_state == c_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_carry_cnt  <= '0;
      r_sample_cnt <= '0;
      r_target     <= '0;
      r_ovf        <= 1'b0;
    end else if (w_start_ok) begin
      r_acc        <= '0;
      r_carry_cnt  <= '0;
      r_sample_cnt <= '0;
      r_target     <= num_samples;
      r_ovf        <= 1'b0;
    end else if (w_transfer) begin
      if (w_sum[ACC_W]) begin
        r_acc <= c_acc_max;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
      r_sample_cnt <= w_sample_nxt;
      if (in_c_out && (r_carry_cnt != c_cnt_max)) begin
        r_carry_cnt <= r_carry_cnt + c_cnt_one;
      end
    end
  end

  assign acc_out    = r_acc;
  assign carry_cnt  = r_carry_cnt;
  assign sample_cnt = r_sample_cnt;
  assign ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// ============================================================================
// Module   : tb_sum_accumulator
// Brief    : Self-checking bench for sum_accumulator: table-driven basic run,
//            directed corner sequences and randomized runs against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_accumulator;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 8;
  localparam int ACC_MAX = 65535;
  localparam int CNT_MAX = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  num_samples;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_c_out;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  carry_cnt;
  logic [CNT_W-1:0]  sample_cnt;
  logic              busy;
  logic              done;
  logic              ovf;

  int n_checks = 0;
  int n_pass   = 0;

  int samp_s [256];
  int samp_c [256];

  typedef struct {
    int a;
    int b;
    int exp_acc;
    int exp_carry;
  } vec_t;

  vec_t basic [7];

  sum_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .in_c_out    (in_c_out),
    .acc_out     (acc_out),
    .carry_cnt   (carry_cnt),
    .sample_cnt  (sample_cnt),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic start_run(input int n);
    start       = 1'b1;
    num_samples = n[CNT_W-1:0];
    in_valid    = 1'($urandom);
    in_sum      = 8'($urandom);
    in_c_out    = 1'($urandom);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Drives one valid sample; start and num_samples are scrambled to prove they are ignored.
  task automatic feed(input int s, input int c);
    in_valid    = 1'b1;
    in_sum      = s[DATA_W-1:0];
    in_c_out    = c[0];
    start       = 1'($urandom);
    num_samples = 8'($urandom);
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Runs n samples from samp_s/samp_c with gap_min..gap_max idle cycles before each one.
  task automatic do_run(input string tag, input int n, input int gap_min, input int gap_max);
    int total;
    int carries;
    int exp_acc;
    total   = 0;
    carries = 0;
    exp_acc = 0;
    start_run(n);
    check({tag, " start busy"}, 32'(busy), 32'd1);
    check({tag, " start acc cleared"}, 32'(acc_out), 32'd0);
    check({tag, " start sample cleared"}, 32'(sample_cnt), 32'd0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_min, gap_max)) begin
        in_valid = 1'b0;
        in_sum   = 8'($urandom);
        in_c_out = 1'($urandom);
        start    = 1'($urandom);
        tick();
        start = 1'b0;
        check({tag, " gap acc hold"}, 32'(acc_out), 32'(exp_acc));
      end
      feed(samp_s[i], samp_c[i]);
      total   += samp_s[i] + 256 * samp_c[i];
      carries += samp_c[i];
      exp_acc  = (total > ACC_MAX) ? ACC_MAX : total;
      check({tag, " acc"}, 32'(acc_out), 32'(exp_acc));
      check({tag, " sample_cnt"}, 32'(sample_cnt), 32'(i + 1));
    end
    check({tag, " done pulse"}, 32'(done), 32'd1);
    check({tag, " ready low in done"}, 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_sum   = 8'hFF;
    in_c_out = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " done cleared"}, 32'(done), 32'd0);
    check({tag, " final acc"}, 32'(acc_out), 32'(exp_acc));
    check({tag, " final carry"}, 32'(carry_cnt), 32'((carries > CNT_MAX) ? CNT_MAX : carries));
    check({tag, " final samples"}, 32'(sample_cnt), 32'(n));
    check({tag, " final ovf"}, 32'(ovf), 32'(total > ACC_MAX));
    tick();
    in_valid = 1'b0;
    check({tag, " idle acc hold"}, 32'(acc_out), 32'(exp_acc));
    check({tag, " idle not busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    basic[0] = '{2,   3,   5,   0};
    basic[1] = '{2,   8,   15,  0};
    basic[2] = '{12,  14,  41,  0};
    basic[3] = '{27,  13,  81,  0};
    basic[4] = '{18,  32,  131, 0};
    basic[5] = '{112, 20,  263, 0};
    basic[6] = '{200, 100, 563, 1};

    rst         = 1'b1;
    start       = 1'($urandom);
    num_samples = 8'($urandom);
    in_valid    = 1'($urandom);
    in_sum      = 8'($urandom);
    in_c_out    = 1'($urandom);
    tick();
    start    = 1'($urandom);
    in_valid = 1'($urandom);
    tick();
    check("reset acc", 32'(acc_out), 32'd0);
    check("reset carry", 32'(carry_cnt), 32'd0);
    check("reset samples", 32'(sample_cnt), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ready", 32'(in_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    tick();

    // Table-driven basic run: each row is an adder operand pair and the running result.
    start_run(7);
    for (int i = 0; i < 7; i++) begin
      int s;
      s = basic[i].a + basic[i].b;
      feed(s % 256, s / 256);
      check("basic acc", 32'(acc_out), 32'(basic[i].exp_acc));
      check("basic carry", 32'(carry_cnt), 32'(basic[i].exp_carry));
      check("basic samples", 32'(sample_cnt), 32'(i + 1));
      check("basic busy", 32'(busy), (i < 6) ? 32'd1 : 32'd0);
      samp_s[i] = s % 256;
      samp_c[i] = s / 256;
    end
    check("basic done", 32'(done), 32'd1);
    check("basic ovf", 32'(ovf), 32'd0);
    tick();
    check("basic back to idle", 32'(done | busy), 32'd0);
    check("basic acc held", 32'(acc_out), 32'd563);

    do_run("gaps", 7, 3, 3);
    check("gaps acc 563", 32'(acc_out), 32'd563);
    check("gaps carry 1", 32'(carry_cnt), 32'd1);

    for (int i = 0; i < 200; i++) begin
      samp_s[i] = 255;
      samp_c[i] = 1;
    end
    do_run("sat", 200, 0, 0);
    check("sat acc", 32'(acc_out), 32'd65535);
    check("sat ovf", 32'(ovf), 32'd1);
    check("sat carry", 32'(carry_cnt), 32'd200);

    start_run(0);
    check("zero done", 32'(done), 32'd1);
    check("zero busy", 32'(busy), 32'd0);
    check("zero acc", 32'(acc_out), 32'd0);
    check("zero ovf", 32'(ovf), 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("zero done over", 32'(done), 32'd0);
    check("zero no sample", 32'(sample_cnt), 32'd0);

    // Mid-run start is ignored, then reset abandons the run.
    start_run(5);
    feed(10, 0);
    feed(20, 1);
    start       = 1'b1;
    num_samples = 8'd0;
    tick();
    start = 1'b0;
    check("midstart busy", 32'(busy), 32'd1);
    check("midstart samples", 32'(sample_cnt), 32'd2);
    check("midstart acc", 32'(acc_out), 32'd286);
    feed(30, 0);
    check("midrst pre acc", 32'(acc_out), 32'd316);
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst acc", 32'(acc_out), 32'd0);
    check("midrst samples", 32'(sample_cnt), 32'd0);
    check("midrst carry", 32'(carry_cnt), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    tick();

    for (int r = 0; r < 6; r++) begin
      int n;
      n = (r == 5) ? 255 : int'($urandom_range(1, 60));
      for (int i = 0; i < n; i++) begin
        samp_s[i] = int'($urandom_range(0, 255));
        samp_c[i] = int'($urandom_range(0, 1));
      end
      do_run("rand", n, 0, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
